// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Uses the start/ready/done_tick handshake, so it chains straight off the Fibonacci FSMD.
module bin2bcd_seq #(
  parameter int W = 20,
  parameter int D = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           ready,
  output logic           done_tick,
  output logic [4*D-1:0] bcd
);

  localparam int NW = $clog2(W + 1);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_OP   = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  logic [1:0]     state_reg, state_next;
  logic [W-1:0]   p_reg, p_next;
  logic [4*D-1:0] bcd_reg, bcd_next;
  logic [NW-1:0]  n_reg, n_next;
  logic [4*D-1:0] adj;
  logic [4*D-1:0] shifted;

  // Add-3 correction on every digit in parallel, before the shift.
  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] > 4'd4) ?
                              bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  // Digit chain takes the binary MSB into the units digit; the top digit's MSB drops off.
  assign shifted = {adj[4*D-2:0], p_reg[W-1]};

  always_comb begin
    state_next = state_reg;
    p_next     = p_reg;
    bcd_next   = bcd_reg;
    n_next     = n_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          p_next     = bin;
          bcd_next   = '0;
          n_next     = NW'(W);
          state_next = S_OP;
        end
      end
      S_OP: begin
        p_next   = {p_reg[W-2:0], 1'b0};
        bcd_next = shifted;
        n_next   = n_reg - NW'(1);
        if (n_reg == NW'(1))
          state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      p_reg     <= '0;
      bcd_reg   <= '0;
      n_reg     <= '0;
    end else begin
      state_reg <= state_next;
      p_reg     <= p_next;
      bcd_reg   <= bcd_next;
      n_reg     <= n_next;
    end
  end

  assign ready     = (state_reg == S_IDLE);
  assign done_tick = (state_reg == S_DONE);
  assign bcd       = bcd_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed boundary cases plus random values
// compared against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  localparam int W = 20;
  localparam int D = 7;

  logic           clk;
  logic           reset;
  logic           start;
  logic [W-1:0]   bin;
  logic           ready;
  logic           done_tick;
  logic [4*D-1:0] bcd;

  int checks_cnt;
  int errors_cnt;

  bin2bcd_seq #(.W(W), .D(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin       (bin),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd       (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks_cnt++;
    if (observed !== expected) begin
      errors_cnt++;
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: decimal digits by repeated division.
  function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
    logic [4*D-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int unsigned fib(input int n);
    int unsigned a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // One conversion; optionally pulses a stray start (bin=123) during op cycle pulse_at.
  task automatic convert(input int unsigned v, input int pulse_at, input string tag);
    int cycles;
    int ready_bad;
    cycles = 0;
    ready_bad = 0;
    @(negedge clk);
    start = 1'b1;
    bin   = W'(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = W'($urandom);
    while (1) begin
      @(negedge clk);
      cycles++;
      if (cycles == pulse_at) begin
        start = 1'b1;
        bin   = W'(123);
      end else if (cycles == pulse_at + 1) begin
        start = 1'b0;
      end
      if (ready) ready_bad++;
      if (done_tick || cycles > 60) break;
    end
    check({tag, "_latency"}, 64'(cycles), 64'(W + 1));
    check({tag, "_ready_low"}, 64'(ready_bad), 64'd0);
    check({tag, "_bcd"}, 64'(bcd), 64'(ref_bcd(v)));
    @(negedge clk);
    check({tag, "_done_width"}, 64'(done_tick), 64'd0);
    check({tag, "_ready_back"}, 64'(ready), 64'd1);
  endtask

  initial begin
    int unsigned v;
    int hold_bad;
    int stray;
    checks_cnt = 0;
    errors_cnt = 0;
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done_tick), 64'd0);
    check("rst_bcd", 64'(bcd), 64'd0);
    reset = 1'b0;

    convert(0, -5, "zero");
    convert(832040, -5, "f30");
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bcd !== 28'h0832040 || ready !== 1'b1) hold_bad++;
    end
    check("f30_hold", 64'(hold_bad), 64'd0);

    convert(9, -5, "b9");
    convert(10, -5, "b10");
    convert(99999, -5, "b99999");
    convert(1048575, -5, "bmax");

    // Stray start mid-op must neither disturb nor queue.
    convert(654321, 5, "stray");
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (!ready || done_tick) stray++;
    end
    check("stray_not_queued", 64'(stray), 64'd0);

    // Asynchronous reset at op cycle 10.
    @(negedge clk);
    start = 1'b1;
    bin   = W'(777777);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_bcd", 64'(bcd), 64'd0);
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_done", 64'(done_tick), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done_tick) stray++;
    end
    check("abort_no_done", 64'(stray), 64'd0);
    convert(500, -5, "after_abort");

    // Upstream Fibonacci FSMD modelled behaviourally: done_tick with f=F(20).
    check("fib20_model", 64'(fib(20)), 64'd6765);
    convert(fib(20), -5, "fib20");

    for (int i = 0; i < 30; i++) begin
      v = $urandom_range((1 << W) - 1, 0);
      convert(v, -5, $sformatf("rand%0d", i));
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
